ic_wr_cmd_tracker: RTL and testbench

Per-master write-command tracker for the AXI fabric. Records the decoded slave for every accepted AW command in a per-ID FIFO and presents the target slave for each W burst of that master. Adds the following on top of a plain per-ID slave registry: full-parameter ID space, AW back-pressure on slot full, same-cycle AW→W bypass, an outstanding-command counter, and optional protocol-error detection. One instance sits on each master port, between the AW decoder and the W mux.

---
 rtl/ic_wr_cmd_tracker.sv | 172 +++++++++++++++++
 tb/tb_ic_wr_cmd_tracker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ic_wr_cmd_tracker.sv
// ic_wr_cmd_tracker
// Per-master write-command tracker. Every accepted AW command records its
// decoded slave in a per-ID FIFO slot; the head of the slot addressed by WID
// steers the W mux. An AW and a W of the same ID arriving together on an
// empty slot bypass the FIFO.
//
// Optional feature: define IC_WR_CMD_CHECK_EN to build the sticky protocol
// error flag ERR (push to a full slot, or a W beat with no backing command).
// Without the macro ERR is tied to 0.
module ic_wr_cmd_tracker #(
  parameter int                  ID_BITS    = 4,
  parameter int                  SLV_BITS   = 3,
  parameter int                  DEPTH_BITS = 2,
  parameter logic [SLV_BITS-1:0] SERR       = {SLV_BITS{1'b1}},
  parameter int                  OUT_BITS   = ID_BITS + DEPTH_BITS + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_BITS-1:0]  AWID,
  input  logic [SLV_BITS-1:0] AWSLV,
  input  logic                AWVALID,
  input  logic                AWREADY,
  output logic                AWSTALL,
  input  logic [ID_BITS-1:0]  WID,
  input  logic                WVALID,
  input  logic                WREADY,
  input  logic                WLAST,
  output logic [SLV_BITS-1:0] WSLV,
  output logic                WOK,
  output logic [OUT_BITS-1:0] OUTSTANDING,
  output logic                ERR
);

  localparam int NUM_IDS   = 1 << ID_BITS;
  localparam int CMD_DEPTH = 1 << DEPTH_BITS;
  localparam int CNT_W     = DEPTH_BITS + 1;
  // A zero-bit pointer is not expressible; a depth-1 slot keeps a 1-bit
  // pointer that never leaves 0.
  localparam int PTR_W     = (DEPTH_BITS > 0) ? DEPTH_BITS : 1;
  localparam int ADDR_W    = ID_BITS + PTR_W;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  // Per-slot state, gathered from the generate blocks for indexed reads.
  logic [CNT_W-1:0]    count_vec  [NUM_IDS];
  logic [PTR_W-1:0]    wr_ptr_vec [NUM_IDS];
  logic [PTR_W-1:0]    rd_ptr_vec [NUM_IDS];

  // Slave storage; slot s occupies addresses {s, ptr}. Not reset: only
  // entries below the slot count are ever presented.
  logic [SLV_BITS-1:0] mem [MEM_DEPTH];

  logic                push;
  logic                pop_req;
  logic                aw_full;
  logic                w_empty;
  logic                bypass;
  logic                pop_eff;
  logic                push_store;
  logic [SLV_BITS-1:0] head_slv;
  logic [OUT_BITS-1:0] out_reg;

  // Advance a FIFO pointer modulo the slot depth.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(CMD_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Handshake decode. AW is masked while reset is held so that a bypass
  // cannot report a valid slave during reset.
  assign push     = AWVALID & AWREADY & reset;
  assign pop_req  = WVALID & WREADY & WLAST;
  assign aw_full  = (count_vec[AWID] == CNT_W'(CMD_DEPTH));
  assign w_empty  = (count_vec[WID] == '0);
  assign bypass   = w_empty & push & (AWID == WID);
  assign pop_eff  = pop_req & ~w_empty;
  // A bypassed command consumed by a same-cycle LAST is never stored.
  assign push_store = push & ~aw_full & ~(bypass & pop_req);

  assign AWSTALL     = aw_full;
  assign OUTSTANDING = out_reg;
  assign head_slv    = mem[{WID, rd_ptr_vec[WID]}];

  // Slave selection for the current W burst: recorded head, then bypass,
  // then the decode-error slave.
  always_comb begin
    WSLV = SERR;
    WOK  = 1'b0;
    if (!w_empty) begin
      WSLV = head_slv;
      WOK  = 1'b1;
    end else if (bypass) begin
      WSLV = AWSLV;
      WOK  = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IDS; gi++) begin : g_slot
      logic [CNT_W-1:0] count_reg;
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic             slot_push;
      logic             slot_pop;

      assign slot_push = push_store & (AWID == ID_BITS'(gi));
      assign slot_pop  = pop_eff & (WID == ID_BITS'(gi));

      // Slot bookkeeping: pointers advance independently, count tracks
      // the net of push and pop.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count_reg  <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (slot_push) begin
            wr_ptr_reg <= next_ptr(wr_ptr_reg);
          end
          if (slot_pop) begin
            rd_ptr_reg <= next_ptr(rd_ptr_reg);
          end
          if (slot_push && !slot_pop) begin
            count_reg <= count_reg + CNT_W'(1);
          end else if (!slot_push && slot_pop) begin
            count_reg <= count_reg - CNT_W'(1);
          end
        end
      end

      assign count_vec[gi]  = count_reg;
      assign wr_ptr_vec[gi] = wr_ptr_reg;
      assign rd_ptr_vec[gi] = rd_ptr_reg;
    end
  endgenerate

  // Record the decoded slave at the tail of the addressed slot.
  always_ff @(posedge clk) begin
    if (push_store) begin
      mem[{AWID, wr_ptr_vec[AWID]}] <= AWSLV;
    end
  end

  // Total recorded commands across all slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg <= '0;
    end else begin
      out_reg <= out_reg + OUT_BITS'(push_store) - OUT_BITS'(pop_eff);
    end
  end

`ifdef IC_WR_CMD_CHECK_EN
  logic err_reg;

  // Sticky protocol error: push into a full slot or an unbacked W beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if ((push & aw_full) | (WVALID & WREADY & ~WOK)) begin
      err_reg <= 1'b1;
    end
  end

  assign ERR = err_reg;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ic_wr_cmd_tracker.sv
// Testbench for ic_wr_cmd_tracker: directed AW/W sequences, a queue-based
// reference model compared on every falling edge, and literal spot checks.
module tb_ic_wr_cmd_tracker;

  localparam int ID_BITS    = 4;
  localparam int SLV_BITS   = 3;
  localparam int DEPTH_BITS = 2;
  localparam int OUT_BITS   = ID_BITS + DEPTH_BITS + 1;
  localparam int NUM_IDS    = 16;
  localparam int CMD_DEPTH  = 4;
  localparam int SERR_VAL   = 7;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [ID_BITS-1:0]  AWID = '0;
  logic [SLV_BITS-1:0] AWSLV = '0;
  logic                AWVALID = 1'b0;
  logic                AWREADY = 1'b0;
  logic                AWSTALL;
  logic [ID_BITS-1:0]  WID = '0;
  logic                WVALID = 1'b0;
  logic                WREADY = 1'b1;
  logic                WLAST = 1'b0;
  logic [SLV_BITS-1:0] WSLV;
  logic                WOK;
  logic [OUT_BITS-1:0] OUTSTANDING;
  logic                ERR;

  int checks = 0;
  int failures = 0;

  ic_wr_cmd_tracker #(
    .ID_BITS(ID_BITS), .SLV_BITS(SLV_BITS), .DEPTH_BITS(DEPTH_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .AWID(AWID), .AWSLV(AWSLV), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWSTALL(AWSTALL),
    .WID(WID), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .WSLV(WSLV), .WOK(WOK), .OUTSTANDING(OUTSTANDING), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue of slave indices per ID.
  int q [NUM_IDS][$];
  bit model_err = 1'b0;
  bit m_push, m_pop, m_full, m_ok, m_bypass_used;
  int m_aid, m_wid;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IDS; i++) q[i].delete();
      model_err = 1'b0;
    end else begin
      m_push = AWVALID && AWREADY;
      m_pop  = WVALID && WREADY && WLAST;
      m_aid  = int'(AWID);
      m_wid  = int'(WID);
      m_full = (q[m_aid].size() == CMD_DEPTH);
      m_ok   = (q[m_wid].size() > 0) || (m_push && m_aid == m_wid);
      if ((m_push && m_full) || (WVALID && WREADY && !m_ok)) model_err = 1'b1;
      m_bypass_used = m_pop && m_push && (m_aid == m_wid) && (q[m_wid].size() == 0);
      if (m_pop && q[m_wid].size() > 0) void'(q[m_wid].pop_front());
      if (m_push && !m_full && !m_bypass_used) q[m_aid].push_back(int'(AWSLV));
    end
  end

  // Every-cycle comparison against the model.
  int e_slv, e_ok, e_stall, e_out, e_err;
  bit e_push;
  always @(negedge clk) begin
    e_push = reset && AWVALID && AWREADY;
    if (q[int'(WID)].size() > 0) begin
      e_slv = q[int'(WID)][0]; e_ok = 1;
    end else if (e_push && AWID == WID) begin
      e_slv = int'(AWSLV); e_ok = 1;
    end else begin
      e_slv = SERR_VAL; e_ok = 0;
    end
    e_stall = (q[int'(AWID)].size() == CMD_DEPTH) ? 1 : 0;
    e_out = 0;
    for (int i = 0; i < NUM_IDS; i++) e_out += q[i].size();
`ifdef IC_WR_CMD_CHECK_EN
    e_err = int'(model_err);
`else
    e_err = 0;
`endif
    if (WVALID || e_ok == 1) chk("model_wslv", int'(WSLV), e_slv);
    chk("model_wok", int'(WOK), e_ok);
    chk("model_awstall", int'(AWSTALL), e_stall);
    chk("model_outstanding", int'(OUTSTANDING), e_out);
    chk("model_err", int'(ERR), e_err);
  end

  // One clock cycle of stimulus, driven just after the rising edge.
  task automatic cyc(input bit awv, input int aid, input int aslv,
                     input bit wv, input int wid, input bit wl);
    @(posedge clk);
    #1;
    AWVALID = awv; AWREADY = awv; AWID = ID_BITS'(aid); AWSLV = SLV_BITS'(aslv);
    WVALID = wv; WID = ID_BITS'(wid); WLAST = wl;
    $display("txn t=%0t aw(v=%0b id=%0d slv=%0d) w(v=%0b id=%0d last=%0b)",
             $time, awv, aid, aslv, wv, wid, wl);
    #2;
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_outstanding", int'(OUTSTANDING), 0);
    chk("rst_wok", int'(WOK), 0);
    chk("rst_wslv", int'(WSLV), SERR_VAL);
    chk("rst_awstall", int'(AWSTALL), 0);
    chk("rst_err", int'(ERR), 0);
    #10 reset = 1'b1;

    // AW ID3 -> slave 2, then a 4-beat W burst.
    cyc(1, 3, 2, 0, 3, 0);
    cyc(0, 0, 0, 1, 3, 0);
    chk("t1_out_after_aw", int'(OUTSTANDING), 1);
    chk("t1_wslv_b1", int'(WSLV), 2);
    chk("t1_wok_b1", int'(WOK), 1);
    cyc(0, 0, 0, 1, 3, 0);
    chk("t1_wslv_b2", int'(WSLV), 2);
    cyc(0, 0, 0, 1, 3, 0);
    chk("t1_wslv_b3", int'(WSLV), 2);
    cyc(0, 0, 0, 1, 3, 1);
    chk("t1_wslv_b4", int'(WSLV), 2);
    chk("t1_out_b4", int'(OUTSTANDING), 1);
    cyc(0, 0, 0, 0, 3, 0);
    chk("t1_out_after_last", int'(OUTSTANDING), 0);

    // Same-cycle bypass on an empty slot.
    cyc(1, 5, 1, 1, 5, 1);
    chk("t2_bypass_wslv", int'(WSLV), 1);
    chk("t2_bypass_wok", int'(WOK), 1);
    cyc(0, 0, 0, 0, 5, 0);
    chk("t2_out_unchanged", int'(OUTSTANDING), 0);

    // Fill slot 0, stall, ignored push to full, then drain in order.
    for (int s = 0; s < 4; s++) cyc(1, 0, s, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_stall_id0", int'(AWSTALL), 1);
    chk("t3_out_full", int'(OUTSTANDING), 4);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t3_stall_id1", int'(AWSTALL), 0);
    cyc(1, 0, 5, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      cyc(0, 0, 0, 1, 0, 1);
      chk($sformatf("t3_pop%0d_wslv", s), int'(WSLV), s);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_out_drained", int'(OUTSTANDING), 0);

    // Interleaved IDs.
    cyc(1, 1, 4, 0, 0, 0);
    cyc(1, 2, 6, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 1);
    chk("t4_wslv_id2", int'(WSLV), 6);
    cyc(0, 0, 0, 1, 1, 1);
    chk("t4_wslv_id1", int'(WSLV), 4);

    // Same-slot push+pop on non-empty slot, and different-slot push+pop.
    cyc(1, 8, 2, 0, 0, 0);
    cyc(1, 8, 3, 1, 8, 1);
    chk("t5_same_slot_head", int'(WSLV), 2);
    cyc(1, 9, 4, 1, 8, 1);
    chk("t5_new_head", int'(WSLV), 3);
    chk("t5_out_same", int'(OUTSTANDING), 1);
    cyc(0, 0, 0, 0, 9, 0);
    chk("t5_out_diff", int'(OUTSTANDING), 1);
    chk("t5_id9_head", int'(WSLV), 4);
    cyc(0, 0, 0, 1, 9, 1);

    // Unbacked W.
    cyc(0, 0, 0, 1, 7, 1);
    chk("t6_wslv_serr", int'(WSLV), SERR_VAL);
    chk("t6_wok0", int'(WOK), 0);
    cyc(0, 0, 0, 0, 7, 0);
`ifdef IC_WR_CMD_CHECK_EN
    chk("t6_err_set", int'(ERR), 1);
`endif

    // Asynchronous reset with commands outstanding.
    cyc(1, 3, 1, 0, 0, 0);
    cyc(1, 4, 2, 0, 0, 0);
    cyc(1, 6, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 3, 0);
    chk("t7_out_pre", int'(OUTSTANDING), 3);
    reset = 1'b0;
    #1;
    chk("t7_out_rst", int'(OUTSTANDING), 0);
    chk("t7_wok_rst", int'(WOK), 0);
    chk("t7_err_rst", int'(ERR), 0);
    #3 reset = 1'b1;
    cyc(1, 3, 5, 0, 3, 0);
    chk("t7_bypass_view", int'(WSLV), 5);
    cyc(0, 0, 0, 0, 3, 0);
    chk("t7_wslv_after", int'(WSLV), 5);
    chk("t7_out_after", int'(OUTSTANDING), 1);
    cyc(0, 0, 0, 1, 3, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
